// File: rtl/sysid_uptime_slave_if.sv
// Avalon-MM bus bundle for the system-ID / uptime slave.
// The master drives the command side; the slave returns the read response.
interface sysid_uptime_slave_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_uptime_slave.sv
// System identification slave: fixed ID and build timestamp, a prescaled
// free-running uptime counter with a coherent 64-bit read snapshot,
// run/clear control, sticky wrap status and two scratch words.
// Reads complete with a fixed latency of one cycle; there is no waitrequest.
module sysid_uptime_slave #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int unsigned UPTIME_WIDTH = 48,     // legal 8..64
    parameter int unsigned PRESCALE     = 1       // legal 1..65535
) (
    input  logic                 clock,
    input  logic                 reset,
    sysid_uptime_slave_if.slave  avs
);

    typedef enum logic [2:0] {
        ADDR_ID        = 3'd0,
        ADDR_TIMESTAMP = 3'd1,
        ADDR_UPTIME_LO = 3'd2,
        ADDR_UPTIME_HI = 3'd3,
        ADDR_CONTROL   = 3'd4,
        ADDR_STATUS    = 3'd5,
        ADDR_SCRATCH0  = 3'd6,
        ADDR_SCRATCH1  = 3'd7
    } reg_addr_e;

    localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

    // Byte-lane merge for the writable words.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    logic [15:0]             r_pcnt;
    logic [UPTIME_WIDTH-1:0] r_uptime;
    logic [31:0]             r_hi_shadow;
    logic                    r_run;
    logic                    r_wrap;
    logic [31:0]             r_scratch0;
    logic [31:0]             r_scratch1;
    logic [31:0]             r_readdata;
    logic                    r_readdatavalid;

    logic        w_tick;
    logic        w_clear;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_wrap_evt;
    logic [63:0] w_uptime64;
    logic [31:0] w_rd_mux;

    // Tick, clear and wrap decode; clear suppresses a coincident tick.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_uptime64 = 64'(r_uptime);
        w_wr_ctrl  = avs.write && (avs.address == ADDR_CONTROL) && avs.byteenable[0];
        w_wr_stat  = avs.write && (avs.address == ADDR_STATUS)  && avs.byteenable[0];
        w_clear    = w_wr_ctrl && avs.writedata[1];
        w_tick     = r_run && (r_pcnt == PCNT_LAST);
        w_wrap_evt = w_tick && !w_clear && (&r_uptime);
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        w_rd_mux = '0;
        case (avs.address)
            ADDR_ID:        w_rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: w_rd_mux = TIMESTAMP;
            ADDR_UPTIME_LO: w_rd_mux = w_uptime64[31:0];
            ADDR_UPTIME_HI: w_rd_mux = r_hi_shadow;
            ADDR_CONTROL:   w_rd_mux = {31'd0, r_run};
            ADDR_STATUS:    w_rd_mux = {31'd0, r_wrap};
            ADDR_SCRATCH0:  w_rd_mux = r_scratch0;
            ADDR_SCRATCH1:  w_rd_mux = r_scratch1;
            default:        w_rd_mux = '0;
        endcase
    end

    // Prescaler and uptime counter; run=0 freezes both, clear zeroes both.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every block samples pre-edge values.
        if (reset) begin
            r_pcnt   <= '0;
            r_uptime <= '0;
        end else if (w_clear) begin
            r_pcnt   <= '0;
            r_uptime <= '0;
        end else if (w_tick) begin
            r_pcnt   <= '0;
            r_uptime <= r_uptime + UPTIME_WIDTH'(1);
        end else if (r_run) begin
            r_pcnt   <= r_pcnt + 16'd1;
        end
    end

    // Run bit and sticky wrap flag; a wrap in the same cycle as W1C keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run  <= 1'b1;
            r_wrap <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_run <= avs.writedata[0];
            if (w_wrap_evt) begin
                r_wrap <= 1'b1;
            end else if (w_wr_stat && avs.writedata[0]) begin
                r_wrap <= 1'b0;
            end
        end
    end

    // Scratch words with per-byte write enables.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scratch0 <= '0;
            r_scratch1 <= '0;
        end else if (avs.write) begin
            if (avs.address == ADDR_SCRATCH0)
                r_scratch0 <= be_merge(r_scratch0, avs.writedata, avs.byteenable);
            if (avs.address == ADDR_SCRATCH1)
                r_scratch1 <= be_merge(r_scratch1, avs.writedata, avs.byteenable);
        end
    end

    // One-cycle read response; reading the low word captures the high word for a coherent pair.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_hi_shadow     <= '0;
        end else begin
            r_readdatavalid <= avs.read;
            r_readdata      <= avs.read ? w_rd_mux : 32'd0;
            if (avs.read && (avs.address == ADDR_UPTIME_LO))
                r_hi_shadow <= w_uptime64[63:32];
        end
    end

    assign avs.readdata      = r_readdata;
    assign avs.readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_uptime_slave.sv
// Bench for sysid_uptime_slave: two instances (48-bit/prescale 4 and
// 8-bit/prescale 1), a cycle model per instance and a read scoreboard.
module tb_sysid_uptime_slave;

    localparam logic [31:0] ID_A = 32'h51A7_0001;
    localparam logic [31:0] TS_A = 32'h2024_0611;
    localparam logic [31:0] ID_B = 32'hB0B0_0002;
    localparam logic [31:0] TS_B = 32'h0000_0BEE;
    localparam int W_A = 48;
    localparam int P_A = 4;
    localparam int W_B = 8;
    localparam int P_B = 1;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } drv_t;

    typedef struct packed {
        logic [15:0] pcnt;
        logic [63:0] up;
        logic [31:0] hi;
        logic        run;
        logic        wrap;
        logic [31:0] s0;
        logic [31:0] s1;
    } mdl_t;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        int          due;
    } sb_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    drv_t drv_a;
    drv_t drv_b;
    mdl_t m_a;
    mdl_t m_b;
    sb_t  sb_a[$];
    sb_t  sb_b[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic        force_a;
    logic [63:0] force_val;

    always #5 clk = ~clk;

    sysid_uptime_slave_if bus_a();
    sysid_uptime_slave_if bus_b();

    assign bus_a.read       = drv_a.read;
    assign bus_a.write      = drv_a.write;
    assign bus_a.address    = drv_a.addr;
    assign bus_a.writedata  = drv_a.wd;
    assign bus_a.byteenable = drv_a.be;
    assign bus_b.read       = drv_b.read;
    assign bus_b.write      = drv_b.write;
    assign bus_b.address    = drv_b.addr;
    assign bus_b.writedata  = drv_b.wd;
    assign bus_b.byteenable = drv_b.be;

    sysid_uptime_slave #(.SYSTEM_ID(ID_A), .TIMESTAMP(TS_A), .UPTIME_WIDTH(W_A), .PRESCALE(P_A))
        dut_a (.clock(clk), .reset(rst_a), .avs(bus_a.slave));

    sysid_uptime_slave #(.SYSTEM_ID(ID_B), .TIMESTAMP(TS_B), .UPTIME_WIDTH(W_B), .PRESCALE(P_B))
        dut_b (.clock(clk), .reset(rst_b), .avs(bus_b.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic mdl_t mdl_rst();
        mdl_t m;
        m = '0;
        m.run = 1'b1;
        return m;
    endfunction

    function automatic mdl_t mdl_force(input mdl_t m, input logic [63:0] v);
        mdl_t n;
        n = m;
        n.up = v;
        return n;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = w[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_rd(input mdl_t m, input logic [2:0] a,
                                           input logic [31:0] id, input logic [31:0] ts);
        case (a)
            3'd0:    return id;
            3'd1:    return ts;
            3'd2:    return m.up[31:0];
            3'd3:    return m.hi;
            3'd4:    return {31'd0, m.run};
            3'd5:    return {31'd0, m.wrap};
            3'd6:    return m.s0;
            default: return m.s1;
        endcase
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input drv_t d, input int presc, input int width);
        mdl_t        n;
        logic [63:0] top;
        logic        tick;
        logic        clr;
        n    = m;
        top  = (width == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
        tick = m.run && (int'(m.pcnt) == presc - 1);
        clr  = d.write && (d.addr == 3'd4) && d.be[0] && d.wd[1];
        if (d.read && d.addr == 3'd2) n.hi = m.up[63:32];
        if (d.write) begin
            case (d.addr)
                3'd4: if (d.be[0]) n.run = d.wd[0];
                3'd5: if (d.be[0] && d.wd[0]) n.wrap = 1'b0;
                3'd6: n.s0 = merge(m.s0, d.wd, d.be);
                3'd7: n.s1 = merge(m.s1, d.wd, d.be);
                default: ;
            endcase
        end
        if (clr) begin
            n.pcnt = '0;
            n.up   = '0;
        end else if (tick) begin
            n.pcnt = '0;
            if (m.up == top) begin
                n.up   = '0;
                n.wrap = 1'b1;
            end else begin
                n.up = m.up + 64'd1;
            end
        end else if (m.run) begin
            n.pcnt = m.pcnt + 16'd1;
        end
        return n;
    endfunction

    // Models advance on every rising edge from the same bus inputs the DUTs see.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        m_a <= rst_a ? mdl_rst() : mdl_step(force_a ? mdl_force(m_a, force_val) : m_a, drv_a, P_A, W_A);
        m_b <= rst_b ? mdl_rst() : mdl_step(m_b, drv_b, P_B, W_B);
    end

    // ---------------- response monitor ----------------
    task automatic mon(input int sel, input logic r, input logic v, input logic [31:0] d);
        sb_t e;
        int  depth;
        depth = (sel == 0) ? sb_a.size() : sb_b.size();
        if (r) begin
            if (sel == 0) sb_a.delete(); else sb_b.delete();
        end else if (v) begin
            if (depth == 0) begin
                check(sel == 0 ? "a_unexpected_rdv" : "b_unexpected_rdv", 64'd1, 64'd0);
            end else begin
                if (sel == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                check(e.tag, 64'(d), 64'(e.exp));
                check({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end else begin
            check(sel == 0 ? "a_idle_zero" : "b_idle_zero", 64'(d), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst_a, bus_a.readdatavalid, bus_a.readdata);
        mon(1, rst_b, bus_b.readdatavalid, bus_b.readdata);
    end

    // ---------------- stimulus ----------------
    // One bus cycle, started at a falling edge; reads push their expected value.
    task automatic op(input int sel, input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input string tag,
                      input logic fixed, input logic [31:0] exp);
        drv_t d;
        sb_t  e;
        d = '{read: rd, write: wr, addr: a, wd: wd, be: be};
        if (sel == 0) drv_a = d; else drv_b = d;
        if (rd) begin
            e.tag = tag;
            e.due = cyc + 1;
            if (fixed)         e.exp = exp;
            else if (sel == 0) e.exp = mdl_rd(m_a, a, ID_A, TS_A);
            else               e.exp = mdl_rd(m_b, a, ID_B, TS_B);
            if (sel == 0) sb_a.push_back(e); else sb_b.push_back(e);
        end
        @(negedge clk);
        if (sel == 0) drv_a = '0; else drv_b = '0;
    endtask

    task automatic rd(input int sel, input logic [2:0] a, input string tag);
        op(sel, 1'b1, 1'b0, a, 32'd0, 4'd0, tag, 1'b0, 32'd0);
    endtask

    task automatic rdx(input int sel, input logic [2:0] a, input string tag, input logic [31:0] exp);
        op(sel, 1'b1, 1'b0, a, 32'd0, 4'd0, tag, 1'b1, exp);
    endtask

    task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
        op(sel, 1'b0, 1'b1, a, wd, be, "", 1'b0, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] frz;
        logic        found;
        sb_t         e;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drv_a = '0;
        drv_b = '0;
        force_a = 1'b0;
        force_val = '0;
        repeat (3) @(negedge clk);
        check("a_rst_rdv",   64'(bus_a.readdatavalid), 64'd0);
        check("a_rst_rdata", 64'(bus_a.readdata),      64'd0);
        check("b_rst_rdv",   64'(bus_b.readdatavalid), 64'd0);

        // Prescale 4: forty clocks after reset release give ten ticks.
        rst_a = 1'b0;
        repeat (40) @(negedge clk);
        rdx(0, 3'd2, "t2_up_after_40", 32'd10);

        // Identification words, back to back.
        rdx(0, 3'd0, "t1_id", ID_A);
        rdx(0, 3'd1, "t1_ts", TS_A);

        // run=0 freezes the counter, run=1 resumes it.
        wr(0, 3'd4, 32'd0, 4'hF);
        frz = m_a.up[31:0];
        repeat (20) @(negedge clk);
        rdx(0, 3'd2, "t2_frozen", frz);
        rdx(0, 3'd4, "t2_run_off", 32'd0);
        wr(0, 3'd4, 32'd1, 4'hF);
        repeat (12) @(negedge clk);
        rd(0, 3'd2, "t2_resumed");

        // Snapshot coherence across the 32-bit boundary.
        wr(0, 3'd4, 32'd0, 4'hF);
        force dut_a.r_uptime = 48'h0000_FFFF_FFFF;
        force_val = 64'h0000_0000_FFFF_FFFF;
        force_a = 1'b1;
        #1 release dut_a.r_uptime;
        @(posedge clk);
        #1 force_a = 1'b0;
        @(negedge clk);
        rdx(0, 3'd2, "t3_lo_all_ones", 32'hFFFF_FFFF);
        wr(0, 3'd4, 32'd1, 4'hF);
        repeat (8) @(negedge clk);
        rdx(0, 3'd3, "t3_hi_snapshot", 32'd0);
        rd(0, 3'd2, "t3_lo_after_carry");
        rdx(0, 3'd3, "t3_hi_new", 32'd1);

        // Scratch byte enables, read-during-write, RO write ignored.
        wr(0, 3'd6, 32'hA5A5_A5A5, 4'hF);
        wr(0, 3'd6, 32'h0000_1234, 4'b0011);
        rdx(0, 3'd6, "t5_be_merge", 32'hA5A5_1234);
        op(0, 1'b1, 1'b1, 3'd6, 32'hDEAD_BEEF, 4'hF, "t5_rw_old", 1'b1, 32'hA5A5_1234);
        rdx(0, 3'd6, "t5_rw_new", 32'hDEAD_BEEF);
        wr(0, 3'd7, 32'hFFFF_FFFF, 4'b0100);
        rdx(0, 3'd7, "t5_scratch1_lane2", 32'h00FF_0000);
        wr(0, 3'd0, 32'h1111_2222, 4'hF);
        rdx(0, 3'd0, "t5_ro_ignored", ID_A);

        // 8-bit counter, prescale 1: wrap after 256 cycles.
        rst_b = 1'b0;
        repeat (256) @(negedge clk);
        rdx(1, 3'd2, "t4_wrapped", 32'd0);
        rdx(1, 3'd5, "t4_sticky", 32'd1);
        wr(1, 3'd5, 32'd1, 4'h1);
        rdx(1, 3'd5, "t4_w1c", 32'd0);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_b.up[7:0] == 8'hFF) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t4_reach_ff", 64'(found), 64'd1);
        wr(1, 3'd5, 32'd1, 4'h1);
        rdx(1, 3'd5, "t4_set_beats_w1c", 32'd1);
        rd(1, 3'd2, "t4_up_after_wrap");
        rdx(1, 3'd3, "t4_hi_narrow", 32'd0);

        // Clear on a tick cycle: counter restarts, run and wrap untouched.
        wr(1, 3'd6, 32'h1234_5678, 4'hF);
        wr(1, 3'd4, 32'd3, 4'h1);
        rdx(1, 3'd2, "t6_cleared", 32'd0);
        rdx(1, 3'd4, "t6_run_kept", 32'd1);
        rdx(1, 3'd5, "t6_wrap_kept", 32'd1);

        // Reset while a read response is pending.
        drv_b = '{read: 1'b1, write: 1'b0, addr: 3'd6, wd: 32'd0, be: 4'd0};
        e.tag = "t6_dropped";
        e.exp = 32'h1234_5678;
        e.due = cyc + 1;
        sb_b.push_back(e);
        @(posedge clk);
        #1 drv_b = '0;
        #1 rst_b = 1'b1;
        #1;
        check("t6_rst_rdv",   64'(bus_b.readdatavalid), 64'd0);
        check("t6_rst_rdata", 64'(bus_b.readdata),      64'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        rdx(1, 3'd2, "t6_rst_uptime", 32'd0);
        rdx(1, 3'd6, "t6_rst_scratch0", 32'd0);
        rdx(1, 3'd5, "t6_rst_wrap", 32'd0);
        rdx(1, 3'd4, "t6_rst_run", 32'd1);
        rdx(1, 3'd3, "t6_rst_hi", 32'd0);
        rdx(1, 3'd1, "t6_ts_b", TS_B);

        repeat (3) @(negedge clk);
        check("a_scoreboard_drained", 64'(sb_a.size()), 64'd0);
        check("b_scoreboard_drained", 64'(sb_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
